alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on both sides.
//  Successor to the 8-bit combinational ALU: widened, registered output with flags.
//  Adds shifts and an iterative multi-cycle multiply.
//  Sits between decode/operand fetch and writeback; one operation in flight at a time.
// PARAMETERS
//  WIDTH       8   operand/result width in bits (>=4)
//  SIGNED_CMP  1   1: SLT/SLTE/lessThan compare two's-complement; 0: unsigned
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      op1/op2/Aluop valid this cycle
//  in_ready   out  1      block can accept an operation this cycle
//  op1        in   WIDTH  operand A
//  op2        in   WIDTH  operand B (shift amount for SHL/SHR)
//  Aluop      in   4      operation, encoding below
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  registered result
//  equal      out  1      op1==op2 of the captured operation
//  lessThan   out  1      op1<op2 (per SIGNED_CMP) of the captured operation
//  zero       out  1      result==0
//  carry      out  1      ADD: carry-out; SUB: borrow (op1<op2 unsigned); else 0
// BEHAVIOUR
//  Aluop: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT, 6 SLTE, 7 EQ, 8 SHL, 9 SHR(logical),
//   10 MUL (low WIDTH bits of product), 11-15 reserved -> result 0, carry 0.
//  SLT/SLTE/EQ: result = {WIDTH-1 zeros, cond}.
//  SHL/SHR: if op2 >= WIDTH then result 0, else shift by op2.
//  Add/sub are modulo 2^WIDTH.
//  Handshake: transfer on in_valid&&in_ready, and on out_valid&&out_ready.
//  FSM states IDLE, BUSY, DONE.
//   IDLE: in_ready=1. Accept non-MUL -> DONE, result registered (latency 1: out_valid next cycle).
//     Accept MUL -> BUSY, operands latched.
//   BUSY: in_ready=0. Shift-add, one op2 bit per cycle, WIDTH cycles, then -> DONE.
//     out_valid rises WIDTH+1 cycles after accept.
//   DONE: out_valid=1.
//     result/flags held stable until out_ready.
//     in_ready=out_ready (back-to-back: accept in the same cycle the result is taken).
//     On out_ready: new accept -> DONE/BUSY as from IDLE; else -> IDLE.
//  Inputs ignored when not accepted; op1/op2 may change freely in BUSY.
//  equal/lessThan are computed from the accepted operands for every op, incl. MUL.
//  Reset (any state, incl. mid-MUL): state IDLE, abort multiply.
//   out_valid=0, result=0, all flags=0, in_ready=1 after reset.
//  out_valid=0 in IDLE/BUSY; result/flags keep last value but are don't-care then.
// STRUCTURE
//  alu_pkg: aluop_t enum (4-bit, encodings above), alu_state_t {IDLE,BUSY,DONE}.
//  Sub-module alu_mul_iter: start, op1, op2 -> busy, done, product[WIDTH-1:0].
//   Shift-add with a cycle counter of $clog2(WIDTH)+1 bits; owns the BUSY timing.
//  Top: combinational single-cycle datapath, FSM, output/flag registers.
// TESTING (WIDTH=8, SIGNED_CMP=1 unless noted)
//  1. AND 0x0F,0xF0 -> result 0x00, zero=1. OR -> 0xFF. XOR -> 0xFF.
//     Each op: out_valid 1 cycle after accept.
//  2. ADD 0xFF,0x01 -> result 0x00, carry=1, zero=1.
//     SUB 0x02,0x03 -> 0xFF, carry=1, lessThan=1.
//  3. SLT 0x80,0x01 -> result 1 (signed); same with SIGNED_CMP=0 -> 0.
//     SLTE/EQ 0x01,0x01 -> result 1, equal=1.
//  4. SHL 0x81,3 -> 0x08. SHR 0x81,7 -> 0x01. SHL 0x81,8 -> 0x00.
//  5. MUL 13,11 -> 0x8F; out_valid exactly 9 cycles after accept; in_ready=0 during BUSY.
//     MUL 0xFF,0xFF -> 0x01.
//  6. out_ready=0 for 5 cycles -> result/flags stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> back-to-back accept.
//     Reset asserted mid-MUL -> out_valid=0, result=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encodings and FSM states for alu_seq
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTE = 4'd6,
    OP_EQ   = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic [WIDTH-1:0] partial;
  logic             last;

  // The final partial sum is exposed combinationally so the top can register
  // the product in the same cycle the last multiplier bit is consumed.
  assign partial = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign busy    = busy_r;
  assign done    = busy_r && last;
  assign product = partial;

  // Latch operands on start, then add/shift once per cycle for WIDTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= op1;
      mplier <= op2;
      cnt    <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIGNED_CMP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       Aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             lessThan,
  output logic             zero,
  output logic             carry
);

  alu_state_t       state;
  alu_state_t       state_n;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             eq;
  logic             lt;

  assign is_mul = (Aluop == OP_MUL);
  assign eq     = (op1 == op2);
  assign lt     = (SIGNED_CMP != 0) ? ($signed(op1) < $signed(op2)) : (op1 < op2);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .op1     (op1),
    .op2     (op2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath for every operation except multiply.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (aluop_t'(Aluop))
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_ADD:  {alu_carry, alu_res} = {1'b0, op1} + {1'b0, op2};
      OP_SUB: begin
        alu_res   = op1 - op2;
        alu_carry = (op1 < op2);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_SLTE: alu_res = {{(WIDTH-1){1'b0}}, lt | eq};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, eq};
      OP_SHL:  alu_res = (op2 >= WIDTH'(WIDTH)) ? '0 : (op1 << op2);
      OP_SHR:  alu_res = (op2 >= WIDTH'(WIDTH)) ? '0 : (op1 >> op2);
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and handshake; a result taken in DONE may be replaced in the same cycle.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        if (mul_done)       state_n = DONE;
        else if (!mul_busy) state_n = IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (in_valid && in_ready) begin
      accept    = 1'b1;
      mul_start = is_mul;
      state_n   = is_mul ? BUSY : DONE;
    end
  end

  // Result and flag registers; compare flags come from the accepted operands, MUL included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      equal    <= 1'b0;
      lessThan <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else if (accept) begin
      equal    <= eq;
      lessThan <= lt;
      if (!is_mul) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        carry  <= alu_carry;
      end
    end else if (mul_done) begin
      result <= mul_product;
      zero   <= (mul_product == '0);
      carry  <= 1'b0;
    end
  end

endmodule
